prog_loader: RTL and testbench
==============================

Name: prog_loader

Overview:
- Instruction encoder and loader, the inverse of the core's control decode.
- Accepts symbolic micro-op requests over a valid/ready handshake and encodes each into a 32-bit LEGv8 word.
- Writes the words sequentially into instruction memory through a registered write port, then appends a halt word.
- Sits between the testbench/host program source and the core's instruction memory; signals done to release the core.

Parameters:
DEPTH, 64, instruction memory words; last slot reserved for halt
ADDR_W, 6, width of mem_addr and count (clog2(DEPTH))

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  single-cycle pulse: clear count/flags, enter LOAD
req_valid  in  1  request present
req_ready  out  1  loader can accept this cycle
req_op  in  5  op select (enum below)
req_rd  in  5  Rd / Rt
req_rn  in  5  Rn
req_rm  in  5  Rm
req_imm  in  26  immediate, two's complement (ADDI: unsigned)
req_cond  in  4  B.cond code
finish  in  1  end of program: append halt, go DONE
mem_we  out  1  imem write strobe (registered)
mem_addr  out  ADDR_W  imem write address (registered)
mem_wdata  out  32  encoded word (registered)
count  out  ADDR_W  words written so far
full  out  1  count == DEPTH-1
illegal  out  1  sticky: bad op or immediate out of range
done  out  1  halt written, program loaded

Behaviour:
- Reset (reset=0, async): state IDLE. mem_we, mem_addr, mem_wdata, count, illegal, done all 0. req_ready=0.
- States: IDLE -start-> LOAD; LOAD -finish-> TERM; TERM (1 cycle) -> DONE; DONE -start-> LOAD.
- start has priority in every state: count=0, illegal=0, done=0, next state LOAD.
- req_ready = (state==LOAD) & ~full, combinational. A handshake occurs on req_valid & req_ready.
- Legal handshake at edge N: at N+1, mem_we=1, mem_addr=old count, mem_wdata=encoding; count increments. Otherwise mem_we=0.
- Illegal handshake: request consumed, no write, count unchanged, illegal set (sticky until start).
- Op enum and opcode bits:
  - 0 ADDI 1001000100
  - 1 ADD 10001011000
  - 2 ADDS 10101011000
  - 3 SUB 11001011000
  - 4 SUBS 11101011000
  - 5 AND 10001010000
  - 6 ORR 10101010000
  - 7 EOR 11001010000
  - 8 LSL 11010011011
  - 9 LSR 11010011010
  - 10 MUL 10011011000
  - 11 SDIV 10011010110
  - 12 LDUR 11111000010
  - 13 STUR 11111000000
  - 14 B 000101
  - 15 BL 100101
  - 16 CBZ 10110100
  - 17 B.cond 01010100
  - 18 BR 11010110000
  - 19-31 illegal
- Formats:
  - R: op[31:21] rm[20:16] shamt[15:10] rn[9:5] rd[4:0].
    - shamt=0, except LSL/LSR: shamt=imm[5:0], rm=0; MUL: 6'b011111; SDIV: 6'b000010.
    - BR: rm=0, rd=0, rn=req_rn.
  - I (ADDI): op[31:22] imm12[21:10] rn rd. imm must be 0..4095, else illegal.
  - D (LDUR/STUR): op[31:21] imm9[20:12] 00[11:10] rn rt. imm must be -256..255.
  - B/BL: op[31:26] imm26.
  - CB: op[31:24] imm19[23:5] then [4:0] = rt for CBZ, or {0,cond} for B.cond. imm must be -2^18..2^18-1.
  - Legal B.cond codes: 0,1,A,B,C,D; any other code is illegal.
- full: req_ready=0 while count==DEPTH-1. The halt slot is always available.
- finish in LOAD with no handshake: TERM writes halt 32'h14000000 (B #0) at count next edge; count+1; then DONE, done=1 held.
- finish with a simultaneous handshake: request written at N+1, halt at N+2, done at N+2.
- finish/req_valid in IDLE, TERM or DONE are ignored; req_ready=0 in these states.
- Reset mid-write: outputs cleared immediately; the in-flight write is dropped.

Test Plan:
- reset, start, ADDI rd=1 rn=0 imm=5 -> one cycle later mem_we=1, addr=0, wdata=0x91001401; count=1.
- ADD rd=3 rn=1 rm=2, then B.cond cond=1 imm=-2, back-to-back -> addr 0: 0x8B020023; addr 1: 0x54FFFFC1; req_ready stays 1.
- ADDI imm=4096, then op=25 -> no writes, illegal=1, count=0; later start -> illegal=0.
- Fill DEPTH-1 words -> full=1, req_ready=0; finish -> halt 0x14000000 at addr DEPTH-1; done=1.
- finish asserted together with an accepted LDUR rt=2 rn=1 imm=-8 -> addr0 0xF85F8022; addr1 0x14000000; done at second write.
- Assert reset low mid-LOAD with a pending write -> all outputs 0 asynchronously, state IDLE, req_ready=0.

Source files
------------

// File: rtl/prog_loader.sv
// prog_loader: encodes symbolic micro-op requests into LEGv8 words and writes
// them sequentially into instruction memory, finishing with a halt word.
module prog_loader #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [4:0]        req_op,
    input  logic [4:0]        req_rd,
    input  logic [4:0]        req_rn,
    input  logic [4:0]        req_rm,
    input  logic [25:0]       req_imm,
    input  logic [3:0]        req_cond,
    input  logic              finish,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [ADDR_W-1:0] count,
    output logic              full,
    output logic              illegal,
    output logic              done
);

    // B #0: the core spins here once the program ends.
    localparam logic [31:0] HALT_WORD = 32'h1400_0000;

    typedef enum logic [1:0] {IDLE, LOAD, TERM, DONE} state_t;

    state_t      state, state_nxt;
    logic        hs;
    logic [32:0] enc;
    logic        enc_ok;
    logic [31:0] enc_word;

    // Immediate range checks on the 26-bit two's-complement request field.
    function automatic logic fits_u12(input logic [25:0] imm);
        return imm[25:12] == 14'd0;
    endfunction

    function automatic logic fits_s9(input logic [25:0] imm);
        return (imm[25:8] == 18'd0) || (imm[25:8] == {18{1'b1}});
    endfunction

    function automatic logic fits_s19(input logic [25:0] imm);
        return (imm[25:18] == 8'd0) || (imm[25:18] == 8'hFF);
    endfunction

    function automatic logic cond_ok(input logic [3:0] c);
        return (c == 4'h0) || (c == 4'h1) || (c == 4'hA) || (c == 4'hB) ||
               (c == 4'hC) || (c == 4'hD);
    endfunction

    // Returns {legal, word}; unknown ops and out-of-range immediates are illegal.
    function automatic logic [32:0] encode(
        input logic [4:0]  op,
        input logic [4:0]  rd,
        input logic [4:0]  rn,
        input logic [4:0]  rm,
        input logic [25:0] imm,
        input logic [3:0]  cond
    );
        logic [31:0] w;
        logic        ok;
        w  = 32'd0;
        ok = 1'b1;
        case (op)
            5'd0:  begin w = {10'b1001000100, imm[11:0], rn, rd}; ok = fits_u12(imm); end
            5'd1:  w = {11'b10001011000, rm, 6'd0, rn, rd};
            5'd2:  w = {11'b10101011000, rm, 6'd0, rn, rd};
            5'd3:  w = {11'b11001011000, rm, 6'd0, rn, rd};
            5'd4:  w = {11'b11101011000, rm, 6'd0, rn, rd};
            5'd5:  w = {11'b10001010000, rm, 6'd0, rn, rd};
            5'd6:  w = {11'b10101010000, rm, 6'd0, rn, rd};
            5'd7:  w = {11'b11001010000, rm, 6'd0, rn, rd};
            5'd8:  w = {11'b11010011011, 5'd0, imm[5:0], rn, rd};
            5'd9:  w = {11'b11010011010, 5'd0, imm[5:0], rn, rd};
            5'd10: w = {11'b10011011000, rm, 6'b011111, rn, rd};
            5'd11: w = {11'b10011010110, rm, 6'b000010, rn, rd};
            5'd12: begin w = {11'b11111000010, imm[8:0], 2'b00, rn, rd}; ok = fits_s9(imm); end
            5'd13: begin w = {11'b11111000000, imm[8:0], 2'b00, rn, rd}; ok = fits_s9(imm); end
            5'd14: w = {6'b000101, imm};
            5'd15: w = {6'b100101, imm};
            5'd16: begin w = {8'b10110100, imm[18:0], rd}; ok = fits_s19(imm); end
            5'd17: begin
                w  = {8'b01010100, imm[18:0], 1'b0, cond};
                ok = fits_s19(imm) && cond_ok(cond);
            end
            5'd18: w = {11'b11010110000, 5'd0, 6'd0, rn, 5'd0};
            default: ok = 1'b0;
        endcase
        return {ok, w};
    endfunction

    assign enc      = encode(req_op, req_rd, req_rn, req_rm, req_imm, req_cond);
    assign enc_ok   = enc[32];
    assign enc_word = enc[31:0];
    assign full     = (count == ADDR_W'(DEPTH - 1));

    // Next-state and handshake decode; start overrides everything.
    always_comb begin
        state_nxt = state;
        req_ready = (state == LOAD) && !full;
        hs        = req_ready && req_valid;
        if (start) begin
            state_nxt = LOAD;
        end else begin
            case (state)
                IDLE: state_nxt = IDLE;
                LOAD: if (finish) state_nxt = TERM;
                TERM: state_nxt = DONE;
                DONE: state_nxt = DONE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    // Registered write port, word counter and status flags.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            count     <= '0;
            illegal   <= 1'b0;
            done      <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            if (start) begin
                count   <= '0;
                illegal <= 1'b0;
                done    <= 1'b0;
            end else if (hs) begin
                if (enc_ok) begin
                    mem_we    <= 1'b1;
                    mem_addr  <= count;
                    mem_wdata <= enc_word;
                    count     <= count + ADDR_W'(1);
                end else begin
                    illegal <= 1'b1;
                end
            end else if (state == TERM) begin
                mem_we    <= 1'b1;
                mem_addr  <= count;
                mem_wdata <= HALT_WORD;
                count     <= count + ADDR_W'(1);
                done      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader with hand-computed encodings.
module tb_prog_loader;

    localparam int DEPTH  = 64;
    localparam int ADDR_W = 6;

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_op;
    logic [4:0]        req_rd;
    logic [4:0]        req_rn;
    logic [4:0]        req_rm;
    logic [25:0]       req_imm;
    logic [3:0]        req_cond;
    logic              finish;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [ADDR_W-1:0] count;
    logic              full;
    logic              illegal;
    logic              done;

    int checks = 0;
    int errors = 0;

    prog_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .start(start),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_op(req_op), .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm),
        .req_imm(req_imm), .req_cond(req_cond), .finish(finish),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .count(count), .full(full), .illegal(illegal), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input logic [4:0] op, input logic [4:0] rd, input logic [4:0] rn,
                           input logic [4:0] rm, input logic [25:0] imm, input logic [3:0] cond);
        req_valid = 1'b1;
        req_op = op; req_rd = rd; req_rn = rn; req_rm = rm; req_imm = imm; req_cond = cond;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; req_valid = 1'b0; finish = 1'b0;
        req_op = '0; req_rd = '0; req_rn = '0; req_rm = '0; req_imm = '0; req_cond = '0;
        #2;
        check("rst_we", 32'(mem_we), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_count", 32'(count), 32'd0);
        check("rst_illegal", 32'(illegal), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_ready", 32'(req_ready), 32'd0);
        step();
        reset = 1'b1;

        // IDLE ignores requests and finish
        set_req(5'd1, 5'd1, 5'd2, 5'd3, 26'd0, 4'd0);
        finish = 1'b1;
        step(); step();
        check("idle_we", 32'(mem_we), 32'd0);
        check("idle_ready", 32'(req_ready), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        req_valid = 1'b0; finish = 1'b0;

        // single ADDI
        pulse_start();
        check("load_ready", 32'(req_ready), 32'd1);
        set_req(5'd0, 5'd1, 5'd0, 5'd0, 26'd5, 4'd0);
        step();
        req_valid = 1'b0;
        check("addi_we", 32'(mem_we), 32'd1);
        check("addi_addr", 32'(mem_addr), 32'd0);
        check("addi_wdata", mem_wdata, 32'h9100_1401);
        check("addi_count", 32'(count), 32'd1);
        step();
        check("addi_we_off", 32'(mem_we), 32'd0);

        // back-to-back ADD, B.cond, MUL, LSL, B
        pulse_start();
        check("restart_count", 32'(count), 32'd0);
        set_req(5'd1, 5'd3, 5'd1, 5'd2, 26'd0, 4'd0);
        step();
        check("add_addr", 32'(mem_addr), 32'd0);
        check("add_wdata", mem_wdata, 32'h8B02_0023);
        check("b2b_ready", 32'(req_ready), 32'd1);
        set_req(5'd17, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFE, 4'd1);
        step();
        check("bcond_we", 32'(mem_we), 32'd1);
        check("bcond_addr", 32'(mem_addr), 32'd1);
        check("bcond_wdata", mem_wdata, 32'h54FF_FFC1);
        set_req(5'd10, 5'd5, 5'd6, 5'd7, 26'd0, 4'd0);
        step();
        check("mul_wdata", mem_wdata, 32'h9B07_7CC5);
        set_req(5'd8, 5'd1, 5'd2, 5'd9, 26'd3, 4'd0);
        step();
        check("lsl_wdata", mem_wdata, 32'hD360_0C41);
        set_req(5'd14, 5'd0, 5'd0, 5'd0, 26'h3FF_FFFF, 4'd0);
        step();
        req_valid = 1'b0;
        check("b_addr", 32'(mem_addr), 32'd4);
        check("b_wdata", mem_wdata, 32'h17FF_FFFF);
        check("b_count", 32'(count), 32'd5);

        // illegal requests
        pulse_start();
        set_req(5'd0, 5'd1, 5'd0, 5'd0, 26'd4096, 4'd0);
        step();
        check("addi_big_we", 32'(mem_we), 32'd0);
        check("addi_big_ill", 32'(illegal), 32'd1);
        set_req(5'd25, 5'd1, 5'd0, 5'd0, 26'd0, 4'd0);
        step();
        check("op25_we", 32'(mem_we), 32'd0);
        set_req(5'd17, 5'd0, 5'd0, 5'd0, 26'd4, 4'd2);
        step();
        req_valid = 1'b0;
        check("cond2_we", 32'(mem_we), 32'd0);
        check("ill_count", 32'(count), 32'd0);
        check("ill_sticky", 32'(illegal), 32'd1);
        pulse_start();
        check("ill_clear", 32'(illegal), 32'd0);

        // fill to DEPTH-1, then halt in the reserved slot
        for (int i = 0; i < DEPTH - 1; i++) begin
            set_req(5'd1, 5'(i), 5'd1, 5'd2, 26'd0, 4'd0);
            step();
            check("fill_addr", 32'(mem_addr), 32'(i));
        end
        check("fill_last_wdata", mem_wdata, 32'h8B02_003E);
        check("full", 32'(full), 32'd1);
        check("full_ready", 32'(req_ready), 32'd0);
        step();
        check("full_no_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        finish = 1'b1;
        step();
        finish = 1'b0;
        check("term_we", 32'(mem_we), 32'd0);
        step();
        check("halt_we", 32'(mem_we), 32'd1);
        check("halt_addr", 32'(mem_addr), 32'(DEPTH - 1));
        check("halt_wdata", mem_wdata, 32'h1400_0000);
        check("halt_done", 32'(done), 32'd1);
        step();
        check("done_held", 32'(done), 32'd1);
        check("done_we_off", 32'(mem_we), 32'd0);
        check("done_ready", 32'(req_ready), 32'd0);

        // finish together with an accepted LDUR
        pulse_start();
        check("start_done_clr", 32'(done), 32'd0);
        set_req(5'd12, 5'd2, 5'd1, 5'd0, 26'h3FF_FFF8, 4'd0);
        finish = 1'b1;
        step();
        req_valid = 1'b0; finish = 1'b0;
        check("ldur_addr", 32'(mem_addr), 32'd0);
        check("ldur_wdata", mem_wdata, 32'hF85F_8022);
        check("ldur_done", 32'(done), 32'd0);
        step();
        check("fh_we", 32'(mem_we), 32'd1);
        check("fh_addr", 32'(mem_addr), 32'd1);
        check("fh_wdata", mem_wdata, 32'h1400_0000);
        check("fh_done", 32'(done), 32'd1);

        // asynchronous reset with a write on the port
        pulse_start();
        set_req(5'd0, 5'd7, 5'd3, 5'd0, 26'd100, 4'd0);
        step();
        req_valid = 1'b0;
        check("pre_rst_we", 32'(mem_we), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_we", 32'(mem_we), 32'd0);
        check("arst_addr", 32'(mem_addr), 32'd0);
        check("arst_wdata", mem_wdata, 32'd0);
        check("arst_count", 32'(count), 32'd0);
        check("arst_ready", 32'(req_ready), 32'd0);
        step();
        reset = 1'b1;
        set_req(5'd1, 5'd1, 5'd1, 5'd1, 26'd0, 4'd0);
        step();
        req_valid = 1'b0;
        check("post_rst_idle_ready", 32'(req_ready), 32'd0);
        check("post_rst_idle_we", 32'(mem_we), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
